top_module_4: RTL and testbench

Single-clock CNN layer datapath (conv → bias → ReLU → buffer → 2:1 max-pool) that forms the accelerator core.
- A 9×9 weight-stationary systolic MAC array is fed by per-row internal ramp sources.
- Column results are biased, rectified, stored per column, then pair-wise max-pooled.
- All stages are enabled and reset by an external sequencer.

---
 rtl/top_module_4_pkg.sv | 17 +
 rtl/top_module_4_systolic_pe.sv | 39 +++
 rtl/top_module_4.sv | 237 +++++++++++++++++++++++
 tb/tb_top_module_4.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_module_4_pkg.sv
// Shared constants and helpers for the CNN layer datapath.
// Word width, array size, address width and a signed max.
package top_module_4_pkg;

    localparam int DATA_SIZE  = 16;
    localparam int ARRAY_SIZE = 9;
    localparam int ADDR_W     = 14;

    // Signed maximum of two data words.
    function automatic logic [DATA_SIZE-1:0] smax(
        input logic [DATA_SIZE-1:0] a,
        input logic [DATA_SIZE-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

endpackage

// File: rtl/top_module_4_systolic_pe.sv
// Weight-stationary systolic PE: passes activation right, psum down.
// Ports: s_clk, reset, enable, s_reset, a_in, p_in, w -> a_out, p_out.
module systolic_pe
    import top_module_4_pkg::*;
#(
    parameter int data_size = DATA_SIZE
) (
    input  logic                 s_clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 s_reset,
    input  logic [data_size-1:0] a_in,
    input  logic [data_size-1:0] p_in,
    input  logic [data_size-1:0] w,
    output logic [data_size-1:0] a_out,
    output logic [data_size-1:0] p_out
);

    logic [2*data_size-1:0] prod;

    // Only the low word of the product is kept; low bits are sign-agnostic.
    assign prod = $signed(a_in) * $signed(w);

    always_ff @(posedge s_clk) begin
        if (!reset) begin
            a_out <= '0;
            p_out <= '0;
        end else if (enable) begin
            if (!s_reset) begin
                a_out <= '0;
                p_out <= '0;
            end else begin
                a_out <= a_in;
                p_out <= p_in + prod[data_size-1:0];
            end
        end
    end

endmodule

// File: rtl/top_module_4.sv
// CNN layer core: systolic conv -> bias -> ReLU -> column buffer -> 2:1 max-pool.
// Ports: sequencer enables/clears in; array, bias, relu, buffer and pool results out.
module top_module_4
    import top_module_4_pkg::*;
#(
    parameter int data_size  = DATA_SIZE,
    parameter int array_size = ARRAY_SIZE,
    parameter int BUF_DEPTH  = 16,
    parameter logic [array_size*data_size-1:0] BIAS = '0
) (
    input  logic                                       s_clk,
    input  logic                                       reset,
    input  logic                                       enable,
    input  logic                                       w_reset,
    input  logic                                       s_reset,
    input  logic                                       bias_reset,
    input  logic                                       clear,
    input  logic                                       maxpool_fill_reset,
    input  logic                                       maxpool_clear,
    input  logic [array_size-1:0]                      relu_clear,
    input  logic [array_size-1:0]                      buffer_fill_reset,
    input  logic                                       weight_write_enable,
    input  logic [array_size*array_size*data_size-1:0] weightin,
    output logic                                       w_done,
    input  logic [array_size-1:0]                      r_en,
    output logic [array_size*data_size-1:0]            systolic_dataout,
    output logic [array_size*data_size-1:0]            macout,
    input  logic [array_size-1:0]                      bias_enable,
    output logic [array_size-1:0]                      bias_done,
    input  logic [array_size-1:0]                      relu_w_en,
    input  logic [array_size-1:0]                      relu_r_en,
    output logic [array_size*data_size-1:0]            relu_out,
    output logic [array_size*data_size-1:0]            buffer_in,
    input  logic [array_size-1:0]                      buffer_fill_enable,
    output logic [array_size-1:0]                      buff_write_enable_out,
    output logic [array_size*ADDR_W-1:0]               buff_fill_address,
    input  logic [array_size-1:0]                      is_empty,
    input  logic [array_size-1:0]                      maxpool_arr_enable,
    input  logic [array_size-1:0]                      maxpool_fill_enable,
    input  logic [array_size-1:0]                      maxpool_arr_r_en,
    output logic [array_size*data_size-1:0]            buffer_out,
    output logic [array_size*data_size-1:0]            max_pool_output1,
    output logic                                       maxpool_done,
    output logic [ADDR_W-1:0]                          maxpool_addr_out
);

    localparam int N     = array_size;
    localparam int D     = data_size;
    localparam int IDX_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(BUF_DEPTH);

    logic [D-1:0]      w_q     [N][N];
    logic [D-1:0]      addr_r  [N];
    logic [D-1:0]      a_bus   [N][N+1];
    logic [D-1:0]      p_bus   [N+1][N];
    logic [ADDR_W-1:0] fill_addr [N];
    logic              done_q;
    logic              pool_hit;
    logic              unused_arr_en;

    // Only column 0 paces the shared pool read address.
    assign unused_arr_en = ^maxpool_arr_enable[N-1:1];

    // Stationary weights; a write lands at the edge, so a MAC in the
    // same cycle still sees the previous weight.
    always_ff @(posedge s_clk) begin
        if (!reset) begin
            w_done <= 1'b0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    w_q[r][c] <= '0;
        end else if (enable) begin
            if (!w_reset) begin
                w_done <= 1'b0;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        w_q[r][c] <= '0;
            end else if (weight_write_enable) begin
                w_done <= 1'b1;
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        w_q[r][c] <= weightin[(r*N+c)*D +: D];
            end
        end
    end

    // Per-row ramp sources.
    always_ff @(posedge s_clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) addr_r[i] <= '0;
        end else if (enable) begin
            for (int i = 0; i < N; i++) begin
                if (!clear)
                    addr_r[i] <= '0;
                else if (r_en[i])
                    addr_r[i] <= addr_r[i] + 1'b1;
            end
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        assign a_bus[r][0] = r_en[r] ? addr_r[r] + 1'b1 : '0;
        assign systolic_dataout[r*D +: D] = a_bus[r][N];
        for (genvar c = 0; c < N; c++) begin : g_pe
            systolic_pe #(.data_size(D)) u_pe (
                .s_clk   (s_clk),
                .reset   (reset),
                .enable  (enable),
                .s_reset (s_reset),
                .a_in    (a_bus[r][c]),
                .p_in    (p_bus[r][c]),
                .w       (w_q[r][c]),
                .a_out   (a_bus[r][c+1]),
                .p_out   (p_bus[r+1][c])
            );
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_col
        logic [D-1:0] b_q;
        logic         bdone_q;
        logic [D-1:0] relu_q;
        logic [D-1:0] hold_q;
        logic [D-1:0] pool_q;
        logic [D-1:0] rd_word;
        logic         wr;
        logic         rd_ok;
        logic [D-1:0] mem [BUF_DEPTH];

        assign p_bus[0][c] = '0;
        assign macout[c*D +: D] = p_bus[N][c];

        always_ff @(posedge s_clk) begin
            if (!reset) begin
                b_q     <= '0;
                bdone_q <= 1'b0;
            end else if (enable) begin
                if (!bias_reset) begin
                    b_q     <= '0;
                    bdone_q <= 1'b0;
                end else if (bias_enable[c]) begin
                    b_q     <= macout[c*D +: D] + BIAS[c*D +: D];
                    bdone_q <= 1'b1;
                end else begin
                    bdone_q <= 1'b0;
                end
            end
        end

        assign bias_done[c] = bdone_q;

        always_ff @(posedge s_clk) begin
            if (!reset)
                relu_q <= '0;
            else if (enable) begin
                if (!relu_clear[c])
                    relu_q <= '0;
                else if (relu_w_en[c])
                    relu_q <= b_q[D-1] ? '0 : b_q;
            end
        end

        assign relu_out[c*D +: D]  = relu_q;
        assign buffer_in[c*D +: D] = relu_r_en[c] ? relu_q : '0;

        assign wr = buffer_fill_enable[c] & (fill_addr[c] < DEPTH_A);
        assign buff_write_enable_out[c] = wr;
        assign buff_fill_address[c*ADDR_W +: ADDR_W] = fill_addr[c];

        always_ff @(posedge s_clk) begin
            if (!reset)
                fill_addr[c] <= '0;
            else if (enable) begin
                if (!buffer_fill_reset[c])
                    fill_addr[c] <= '0;
                else if (wr)
                    fill_addr[c] <= fill_addr[c] + 1'b1;
            end
        end

        // Storage has no reset; only the fill pointer is cleared.
        always_ff @(posedge s_clk) begin
            if (reset && enable && buffer_fill_reset[c] && wr)
                mem[fill_addr[c][IDX_W-1:0]] <= buffer_in[c*D +: D];
        end

        assign rd_ok   = maxpool_addr_out < DEPTH_A;
        assign rd_word = (maxpool_arr_r_en[c] & ~is_empty[c] & rd_ok)
                         ? mem[maxpool_addr_out[IDX_W-1:0]] : '0;
        assign buffer_out[c*D +: D] = rd_word;

        // Even address captures the first of a pair, odd address pools it.
        always_ff @(posedge s_clk) begin
            if (!reset) begin
                hold_q <= '0;
                pool_q <= '0;
            end else if (enable) begin
                if (!maxpool_clear) begin
                    hold_q <= '0;
                    pool_q <= '0;
                end else if (maxpool_fill_enable[c]) begin
                    if (!maxpool_addr_out[0])
                        hold_q <= rd_word;
                    else
                        pool_q <= smax(hold_q, rd_word);
                end
            end
        end

        assign max_pool_output1[c*D +: D] = pool_q;
    end

    assign pool_hit = (maxpool_addr_out == fill_addr[0])
                      && (fill_addr[0] != '0);

    always_ff @(posedge s_clk) begin
        if (!reset) begin
            maxpool_addr_out <= '0;
            done_q           <= 1'b0;
        end else if (enable) begin
            if (!maxpool_fill_reset) begin
                maxpool_addr_out <= '0;
                done_q           <= 1'b0;
            end else begin
                if (maxpool_arr_enable[0] && !pool_hit
                    && maxpool_addr_out != fill_addr[0])
                    maxpool_addr_out <= maxpool_addr_out + 1'b1;
                if (pool_hit)
                    done_q <= 1'b1;
            end
        end
    end

    // Done shows as soon as the read pointer meets the fill level.
    assign maxpool_done = done_q | pool_hit;

endmodule

// File: tb/tb_top_module_4.sv
// Directed bench for top_module_4.
// Drives scenario tasks in sequence and prints a summary line.
module tb_top_module_4;

    localparam int N = 9;
    localparam int D = 16;
    localparam int A = 14;

    logic             s_clk;
    logic             reset;
    logic             enable;
    logic             w_reset;
    logic             s_reset;
    logic             bias_reset;
    logic             clear;
    logic             maxpool_fill_reset;
    logic             maxpool_clear;
    logic [N-1:0]     relu_clear;
    logic [N-1:0]     buffer_fill_reset;
    logic             weight_write_enable;
    logic [N*N*D-1:0] weightin;
    logic             w_done;
    logic [N-1:0]     r_en;
    logic [N*D-1:0]   systolic_dataout;
    logic [N*D-1:0]   macout;
    logic [N-1:0]     bias_enable;
    logic [N-1:0]     bias_done;
    logic [N-1:0]     relu_w_en;
    logic [N-1:0]     relu_r_en;
    logic [N*D-1:0]   relu_out;
    logic [N*D-1:0]   buffer_in;
    logic [N-1:0]     buffer_fill_enable;
    logic [N-1:0]     buff_write_enable_out;
    logic [N*A-1:0]   buff_fill_address;
    logic [N-1:0]     is_empty;
    logic [N-1:0]     maxpool_arr_enable;
    logic [N-1:0]     maxpool_fill_enable;
    logic [N-1:0]     maxpool_arr_r_en;
    logic [N*D-1:0]   buffer_out;
    logic [N*D-1:0]   max_pool_output1;
    logic             maxpool_done;
    logic [A-1:0]     maxpool_addr_out;

    int checks;
    int errors;

    top_module_4 dut (
        .s_clk                 (s_clk),
        .reset                 (reset),
        .enable                (enable),
        .w_reset               (w_reset),
        .s_reset               (s_reset),
        .bias_reset            (bias_reset),
        .clear                 (clear),
        .maxpool_fill_reset    (maxpool_fill_reset),
        .maxpool_clear         (maxpool_clear),
        .relu_clear            (relu_clear),
        .buffer_fill_reset     (buffer_fill_reset),
        .weight_write_enable   (weight_write_enable),
        .weightin              (weightin),
        .w_done                (w_done),
        .r_en                  (r_en),
        .systolic_dataout      (systolic_dataout),
        .macout                (macout),
        .bias_enable           (bias_enable),
        .bias_done             (bias_done),
        .relu_w_en             (relu_w_en),
        .relu_r_en             (relu_r_en),
        .relu_out              (relu_out),
        .buffer_in             (buffer_in),
        .buffer_fill_enable    (buffer_fill_enable),
        .buff_write_enable_out (buff_write_enable_out),
        .buff_fill_address     (buff_fill_address),
        .is_empty              (is_empty),
        .maxpool_arr_enable    (maxpool_arr_enable),
        .maxpool_fill_enable   (maxpool_fill_enable),
        .maxpool_arr_r_en      (maxpool_arr_r_en),
        .buffer_out            (buffer_out),
        .max_pool_output1      (max_pool_output1),
        .maxpool_done          (maxpool_done),
        .maxpool_addr_out      (maxpool_addr_out)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    task automatic tick();
        @(posedge s_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic set_idle();
        enable              = 1'b1;
        w_reset             = 1'b1;
        s_reset             = 1'b1;
        bias_reset          = 1'b1;
        clear               = 1'b1;
        maxpool_fill_reset  = 1'b1;
        maxpool_clear       = 1'b1;
        relu_clear          = '1;
        buffer_fill_reset   = '1;
        weight_write_enable = 1'b0;
        weightin            = '0;
        r_en                = '0;
        bias_enable         = '0;
        relu_w_en           = '0;
        relu_r_en           = '0;
        buffer_fill_enable  = '0;
        is_empty            = '0;
        maxpool_arr_enable  = '0;
        maxpool_fill_enable = '0;
        maxpool_arr_r_en    = '0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        ticks(3);
        checks++; if (w_done !== 1'b0) begin errors++;
            $display("FAIL rst_w_done got %h want 0", w_done); end
        checks++; if (systolic_dataout !== '0) begin errors++;
            $display("FAIL rst_sysout got %h want 0", systolic_dataout); end
        checks++; if (macout !== '0) begin errors++;
            $display("FAIL rst_macout got %h want 0", macout); end
        checks++; if (bias_done !== '0) begin errors++;
            $display("FAIL rst_bias_done got %h want 0", bias_done); end
        checks++; if (relu_out !== '0) begin errors++;
            $display("FAIL rst_relu got %h want 0", relu_out); end
        checks++; if (buffer_in !== '0) begin errors++;
            $display("FAIL rst_buf_in got %h want 0", buffer_in); end
        checks++; if (buff_write_enable_out !== '0) begin errors++;
            $display("FAIL rst_wr_en got %h want 0", buff_write_enable_out); end
        checks++; if (buff_fill_address !== '0) begin errors++;
            $display("FAIL rst_fill_addr got %h want 0", buff_fill_address); end
        checks++; if (buffer_out !== '0) begin errors++;
            $display("FAIL rst_buf_out got %h want 0", buffer_out); end
        checks++; if (max_pool_output1 !== '0) begin errors++;
            $display("FAIL rst_pool got %h want 0", max_pool_output1); end
        checks++; if (maxpool_done !== 1'b0) begin errors++;
            $display("FAIL rst_mp_done got %h want 0", maxpool_done); end
        checks++; if (maxpool_addr_out !== '0) begin errors++;
            $display("FAIL rst_mp_addr got %h want 0", maxpool_addr_out); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_weights();
        for (int i = 0; i < N*N; i++) weightin[i*D +: D] = 16'd1;
        weight_write_enable = 1'b1;
        enable = 1'b0;
        tick();
        checks++; if (w_done !== 1'b0) begin errors++;
            $display("FAIL w_frozen got %h want 0", w_done); end
        enable = 1'b1;
        tick();
        weight_write_enable = 1'b0;
        checks++; if (w_done !== 1'b1) begin errors++;
            $display("FAIL w_done got %h want 1", w_done); end
        checks++; if (systolic_dataout !== '0) begin errors++;
            $display("FAIL w_sysout got %h want 0", systolic_dataout); end
        checks++; if (macout !== '0) begin errors++;
            $display("FAIL w_macout got %h want 0", macout); end
        tick();
        checks++; if (w_done !== 1'b1) begin errors++;
            $display("FAIL w_done_hold got %h want 1", w_done); end
    endtask

    task automatic test_systolic();
        s_reset = 1'b0;
        clear = 1'b0;
        tick();
        s_reset = 1'b1;
        clear = 1'b1;
        r_en = 9'd1;
        tick();
        r_en = '0;
        ticks(7);
        checks++; if (systolic_dataout[0 +: D] !== 16'd0) begin errors++;
            $display("FAIL sys_c8 got %h want 0", systolic_dataout[0 +: D]); end
        checks++; if (macout[0 +: D] !== 16'd0) begin errors++;
            $display("FAIL mac0_c8 got %h want 0", macout[0 +: D]); end
        tick();
        checks++; if (systolic_dataout[0 +: D] !== 16'd1) begin errors++;
            $display("FAIL sys_c9 got %h want 1", systolic_dataout[0 +: D]); end
        checks++; if (macout[0 +: D] !== 16'd1) begin errors++;
            $display("FAIL mac0_c9 got %h want 1", macout[0 +: D]); end
        ticks(7);
        checks++; if (macout[8*D +: D] !== 16'd0) begin errors++;
            $display("FAIL mac8_c16 got %h want 0", macout[8*D +: D]); end
        tick();
        checks++; if (macout[8*D +: D] !== 16'd1) begin errors++;
            $display("FAIL mac8_c17 got %h want 1", macout[8*D +: D]); end
        checks++; if (macout[0 +: D] !== 16'd0) begin errors++;
            $display("FAIL mac0_c17 got %h want 0", macout[0 +: D]); end
    endtask

    task automatic test_neg_bias();
        w_reset = 1'b0;
        s_reset = 1'b0;
        clear = 1'b0;
        tick();
        w_reset = 1'b1;
        s_reset = 1'b1;
        clear = 1'b1;
        r_en = 9'd1;
        tick();
        weightin = '0;
        weightin[0 +: D] = 16'hFFFF;
        weight_write_enable = 1'b1;
        tick();
        weight_write_enable = 1'b0;
        tick();
        r_en = '0;
        bias_enable[0] = 1'b1;
        relu_w_en[0] = 1'b1;
        relu_r_en[0] = 1'b1;
        ticks(7);
        checks++; if (macout[0 +: D] !== 16'h0000) begin errors++;
            $display("FAIL neg_mac_c10 got %h want 0000", macout[0 +: D]); end
        tick();
        checks++; if (macout[0 +: D] !== 16'hFFFD) begin errors++;
            $display("FAIL neg_mac got %h want fffd", macout[0 +: D]); end
        tick();
        checks++; if (bias_done[0] !== 1'b1) begin errors++;
            $display("FAIL bias_done got %h want 1", bias_done[0]); end
        bias_enable[0] = 1'b0;
        tick();
        checks++; if (relu_out[0 +: D] !== 16'h0000) begin errors++;
            $display("FAIL relu_neg got %h want 0000", relu_out[0 +: D]); end
        checks++; if (bias_done[0] !== 1'b0) begin errors++;
            $display("FAIL bias_done_off got %h want 0", bias_done[0]); end
        relu_w_en[0] = 1'b0;
        relu_r_en[0] = 1'b0;
    endtask

    // Streams four values into column 0 via W[0][0] while row 0 injects 1.
    task automatic fill4(input logic [D-1:0] v0, input logic [D-1:0] v1,
                         input logic [D-1:0] v2, input logic [D-1:0] v3);
        logic [D-1:0] v [4];
        v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
        w_reset = 1'b0;
        s_reset = 1'b0;
        clear = 1'b0;
        tick();
        w_reset = 1'b1;
        s_reset = 1'b1;
        r_en = 9'd1;
        bias_enable[0] = 1'b1;
        relu_w_en[0] = 1'b1;
        relu_r_en[0] = 1'b1;
        weight_write_enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            weightin = '0;
            weightin[0 +: D] = v[i];
            tick();
        end
        weightin = '0;
        tick();
        weight_write_enable = 1'b0;
        ticks(7);
        buffer_fill_enable[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (buffer_in[0 +: D] !== v[i]) begin errors++;
                $display("FAIL fill_in%0d got %h want %h", i, buffer_in[0 +: D], v[i]); end
            tick();
        end
        buffer_fill_enable[0] = 1'b0;
        r_en = '0;
        clear = 1'b1;
        bias_enable[0] = 1'b0;
    endtask

    task automatic test_fill();
        fill4(16'd3, 16'd7, 16'd2, 16'd5);
        checks++; if (buff_fill_address[0 +: A] !== 14'd4) begin errors++;
            $display("FAIL fill_addr got %0d want 4", buff_fill_address[0 +: A]); end
    endtask

    task automatic test_full();
        int exp;
        buffer_fill_enable[0] = 1'b1;
        for (int i = 0; i < 17; i++) begin
            exp = (4 + i < 16) ? 4 + i : 16;
            checks++; if (buff_fill_address[0 +: A] !== A'(exp)) begin errors++;
                $display("FAIL full_addr%0d got %0d want %0d", i, buff_fill_address[0 +: A], exp); end
            checks++; if (buff_write_enable_out[0] !== (exp < 16)) begin errors++;
                $display("FAIL full_we%0d got %h want %h", i, buff_write_enable_out[0], exp < 16); end
            tick();
        end
        checks++; if (buff_fill_address[0 +: A] !== 14'd16) begin errors++;
            $display("FAIL full_end got %0d want 16", buff_fill_address[0 +: A]); end
        checks++; if (buff_write_enable_out[0] !== 1'b0) begin errors++;
            $display("FAIL full_we_end got %h want 0", buff_write_enable_out[0]); end
        buffer_fill_enable[0] = 1'b0;
    endtask

    task automatic test_pool(input logic [D-1:0] v0, input logic [D-1:0] v1,
                             input logic [D-1:0] v2, input logic [D-1:0] v3,
                             input logic [D-1:0] e0, input logic [D-1:0] e1);
        buffer_fill_reset[0] = 1'b0;
        tick();
        buffer_fill_reset[0] = 1'b1;
        checks++; if (buff_fill_address[0 +: A] !== 14'd0) begin errors++;
            $display("FAIL pool_fill_rst got %0d want 0", buff_fill_address[0 +: A]); end
        fill4(v0, v1, v2, v3);
        maxpool_fill_reset = 1'b0;
        maxpool_clear = 1'b0;
        tick();
        maxpool_fill_reset = 1'b1;
        maxpool_clear = 1'b1;
        checks++; if (max_pool_output1[0 +: D] !== 16'd0) begin errors++;
            $display("FAIL pool_clr got %h want 0", max_pool_output1[0 +: D]); end
        maxpool_arr_enable[0] = 1'b1;
        maxpool_fill_enable[0] = 1'b1;
        maxpool_arr_r_en[0] = 1'b1;
        #1;
        checks++; if (buffer_out[0 +: D] !== v0) begin errors++;
            $display("FAIL pool_rd0 got %h want %h", buffer_out[0 +: D], v0); end
        tick();
        checks++; if (buffer_out[0 +: D] !== v1) begin errors++;
            $display("FAIL pool_rd1 got %h want %h", buffer_out[0 +: D], v1); end
        tick();
        checks++; if (max_pool_output1[0 +: D] !== e0) begin errors++;
            $display("FAIL pool_out0 got %h want %h", max_pool_output1[0 +: D], e0); end
        checks++; if (maxpool_done !== 1'b0) begin errors++;
            $display("FAIL pool_done_early got %h want 0", maxpool_done); end
        ticks(2);
        checks++; if (max_pool_output1[0 +: D] !== e1) begin errors++;
            $display("FAIL pool_out1 got %h want %h", max_pool_output1[0 +: D], e1); end
        checks++; if (maxpool_addr_out !== 14'd4) begin errors++;
            $display("FAIL pool_addr got %0d want 4", maxpool_addr_out); end
        checks++; if (maxpool_done !== 1'b1) begin errors++;
            $display("FAIL pool_done got %h want 1", maxpool_done); end
        maxpool_arr_enable[0] = 1'b0;
        maxpool_fill_enable[0] = 1'b0;
        tick();
        checks++; if (maxpool_done !== 1'b1) begin errors++;
            $display("FAIL pool_done_hold got %h want 1", maxpool_done); end
        maxpool_fill_reset = 1'b0;
        tick();
        maxpool_fill_reset = 1'b1;
        checks++; if (maxpool_done !== 1'b0) begin errors++;
            $display("FAIL pool_done_clr got %h want 0", maxpool_done); end
        checks++; if (buffer_out[0 +: D] !== v0) begin errors++;
            $display("FAIL pool_rd_back got %h want %h", buffer_out[0 +: D], v0); end
        is_empty[0] = 1'b1;
        #1;
        checks++; if (buffer_out[0 +: D] !== 16'd0) begin errors++;
            $display("FAIL pool_empty got %h want 0", buffer_out[0 +: D]); end
        is_empty[0] = 1'b0;
        maxpool_arr_r_en[0] = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        set_idle();
        test_reset();
        test_weights();
        test_systolic();
        test_neg_bias();
        test_fill();
        test_full();
        test_pool(16'd3, 16'd7, 16'd2, 16'd5, 16'd7, 16'd5);
        test_pool(16'd9, 16'd4, 16'd8, 16'd1, 16'd9, 16'd8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
